// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline control for the five-stage core.
// Detects load-use hazards, taken-branch redirects and multi-cycle mul/div
// occupancy, and drives the decode bubble (halt_control), fetch stall and
// fetch flush. It is the only source of halt_control.
//
// Parameters:
//   MUL_LAT  EX busy cycles for multiply (1..63)
//   DIV_LAT  EX busy cycles for divide   (1..63)
// Ports:
//   clk, reset          rising-edge clock, async active-high reset
//   dec_rs/dec_rt       decode source registers, dec_uses_rs/rt qualify them
//   ex_load, ex_rd      load in EX and its destination register
//   ex_branch_taken     taken branch/jump resolved in EX
//   ex_muldiv_start     mul/div entering EX, ex_muldiv_div selects divide
//   halt_control        decode latches a bubble at the next edge
//   stall_if, flush_if  fetch hold / fetch discard
//   muldiv_busy/done    mul/div in progress / last busy cycle pulse
//   stall_count         stall-cycle counter
// Build option:
//   PIPE_HAZARD_STALL_CNT_EN  builds the stall_count register; otherwise
//                             stall_count is tied to zero.
module pipe_hazard_ctrl #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  dec_rs,
    input  logic [4:0]  dec_rt,
    input  logic        dec_uses_rs,
    input  logic        dec_uses_rt,
    input  logic        ex_load,
    input  logic [4:0]  ex_rd,
    input  logic        ex_branch_taken,
    input  logic        ex_muldiv_start,
    input  logic        ex_muldiv_div,
    output logic        halt_control,
    output logic        stall_if,
    output logic        flush_if,
    output logic        muldiv_busy,
    output logic        muldiv_done,
    output logic [31:0] stall_count
);

    typedef enum logic [1:0] {StRun, StFlush, StMuldiv} state_e;

    state_e     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic       lu;

    assign lu = ex_load && (ex_rd != 5'd0) &&
                ((dec_uses_rs && (dec_rs == ex_rd)) || (dec_uses_rt && (dec_rt == ex_rd)));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        halt_control = 1'b0;
        stall_if     = 1'b0;
        flush_if     = 1'b0;
        muldiv_busy  = 1'b0;
        muldiv_done  = 1'b0;
        unique case (state_q)
            StRun: begin
                if (ex_branch_taken) begin
                    halt_control = 1'b1;
                    flush_if     = 1'b1;
                    state_d      = StFlush;
                end else if (ex_muldiv_start) begin
                    // No stall in the start cycle; the unit occupies EX from next cycle.
                    cnt_d   = ex_muldiv_div ? 6'(DIV_LAT) : 6'(MUL_LAT);
                    state_d = StMuldiv;
                end else if (lu) begin
                    halt_control = 1'b1;
                    stall_if     = 1'b1;
                end
            end
            StFlush: begin
                // EX holds the killed wrong-path instruction: ignore ex_* inputs.
                halt_control = 1'b1;
                state_d      = StRun;
            end
            StMuldiv: begin
                halt_control = 1'b1;
                stall_if     = 1'b1;
                muldiv_busy  = 1'b1;
                cnt_d        = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    muldiv_done = 1'b1;
                    state_d     = StRun;
                end
            end
            default: state_d = StRun;
        endcase
        // Reset overrides the outputs combinationally so they drop before the next edge.
        if (reset) begin
            halt_control = 1'b1;
            stall_if     = 1'b0;
            flush_if     = 1'b0;
            muldiv_busy  = 1'b0;
            muldiv_done  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StRun;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PIPE_HAZARD_STALL_CNT_EN
    logic [31:0] stall_count_q, stall_count_d;

    // Wraps naturally at 2^32.
    always_comb begin
        stall_count_d = stall_count_q + {31'd0, stall_if};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_q <= 32'd0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
`else
    assign stall_count = 32'h0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline control unit for the five-stage core. It detects load-use hazards, taken-branch redirects and multi-cycle multiply/divide occupancy. From these it drives the decode stage's `halt_control` input (bubble insert), the fetch stall and the fetch flush. It sits beside the IF/ID/EX stages and is the only source of `halt_control`.

## Interface
Parameters:
- `MUL_LAT`, default 4: EX busy cycles for multiply; legal range 1..63.
- `DIV_LAT`, default 32: EX busy cycles for divide; legal range 1..63.

Ports:
- `clk`  in  1  global clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `dec_rs`  in  5  source register of the instruction in decode (decode `rs_reg`).
- `dec_rt`  in  5  source register of the instruction in decode (decode `rt_reg`).
- `dec_uses_rs`  in  1  decode instruction reads `dec_rs`.
- `dec_uses_rt`  in  1  decode instruction reads `dec_rt`.
- `ex_load`  in  1  valid load in EX.
- `ex_rd`  in  5  destination register of the load in EX.
- `ex_branch_taken`  in  1  valid taken branch/jump resolved in EX.
- `ex_muldiv_start`  in  1  valid mul/div entering EX.
- `ex_muldiv_div`  in  1  qualifies start: 1 = divide, 0 = multiply.
- `halt_control`  out  1  decode latches a bubble (`halt_out` = 1) at the next edge.
- `stall_if`  out  1  PC and IF/ID register hold.
- `flush_if`  out  1  IF discards the fetched instruction.
- `muldiv_busy`  out  1  mul/div in progress.
- `muldiv_done`  out  1  one-cycle pulse in the last busy cycle.
- `stall_count`  out  32  stall-cycle counter (see Configuration).

## Operation
- State register: RUN, FLUSH, MULDIV. A 6-bit down-counter `cnt` belongs to MULDIV.
- Asynchronous reset: state goes to RUN, `cnt` to 0, `stall_count` to 0.
- While `reset` = 1, outputs are forced to: `halt_control` = 1, `stall_if` = 0, `flush_if` = 0, `muldiv_busy` = 0, `muldiv_done` = 0.
- Load-use hazard (`lu`) = `ex_load` && `ex_rd` != 0 && (match on rs or rt), where:
  - rs match = `dec_uses_rs` && `dec_rs` == `ex_rd`;
  - rt match = `dec_uses_rt` && `dec_rt` == `ex_rd`.
- RUN state, evaluated in priority order:
  1. `ex_branch_taken`: assert `halt_control` = 1 and `flush_if` = 1; go to FLUSH. `ex_muldiv_start` and `lu` are ignored in that cycle.
  2. `ex_muldiv_start`: load `cnt` with `DIV_LAT` or `MUL_LAT`; go to MULDIV. No stall in the start cycle.
  3. `lu`: assert `halt_control` = 1 and `stall_if` = 1 for this cycle only; stay in RUN. The load advances, so `lu` clears on the next cycle.
  4. Otherwise all outputs are 0.
- FLUSH state (exactly 1 cycle):
  - `halt_control` = 1; `stall_if` = 0; `flush_if` = 0.
  - All `ex_*` inputs are ignored, because EX holds a killed instruction.
  - Return to RUN.
- MULDIV state:
  - `muldiv_busy`, `stall_if` and `halt_control` are all 1.
  - `cnt` decrements each cycle.
  - When `cnt` == 1: pulse `muldiv_done` and go to RUN.
  - All `ex_*` and `dec_*` inputs are ignored.
- Reset asserted mid-FLUSH or mid-MULDIV aborts immediately to RUN; no `muldiv_done` is issued.

## Timing
- Load-use: Mealy output, combinational from the inputs, valid in the same cycle t.
  - Decode inserts a bubble at edge t+1 while IF/ID holds.
  - Total penalty: 1 cycle.
- Branch taken at cycle t:
  - `flush_if` is high in cycle t.
  - `halt_control` is high in cycles t and t+1.
  - Penalty: 2 cycles (both wrong-path instructions killed).
- Mul/div start at cycle t:
  - `muldiv_busy` is high for cycles t+1 .. t+LAT.
  - `muldiv_done` is high in cycle t+LAT.
  - RUN resumes at cycle t+LAT+1.
- All registered state updates on the rising edge of `clk`. No output has more than one cycle of latency from its cause.

## Configuration
- `PIPE_HAZARD_STALL_CNT_EN` defined:
  - `stall_count` increments on every edge where `stall_if` = 1.
  - Wraps from 0xFFFF_FFFF to 0.
  - Cleared by `reset`.
- Not defined: no counter register is built, and `stall_count` is tied to 32'h0.

## Test plan
- Load `ex_rd` = 5 with `dec_rs` = 5 and `dec_uses_rs` = 1, then release → `halt_control` = `stall_if` = 1 for exactly one cycle. Repeat with `ex_rd` = 0 → no stall.
- `ex_branch_taken` pulse at cycle 10 → `flush_if` high in cycle 10 only; `halt_control` high in cycles 10–11; cycle 12 all outputs 0.
- `ex_muldiv_start` with `ex_muldiv_div` = 1 and `DIV_LAT` = 32, start at cycle 5 → `muldiv_busy` high for cycles 6–37, `muldiv_done` high in cycle 37, RUN in cycle 38. Repeat with multiply, `MUL_LAT` = 4 → busy for cycles 6–9.
- `ex_branch_taken`, `ex_muldiv_start` and `lu` asserted together in RUN → branch behaviour only; no MULDIV entry.
- Assert `reset` asynchronously at divide cycle 10 → outputs drop to their reset values before the next edge; after release, state is RUN with `muldiv_done` never pulsed.
- With `PIPE_HAZARD_STALL_CNT_EN` defined, after one load-use and one `MUL_LAT` = 4 multiply → `stall_count` = 5. Without the macro → `stall_count` = 0.
